seven_seg_mux_n: RTL and testbench
==================================

Name: seven_seg_mux_n

Overview:
- Parametrised N-digit, time-multiplexed seven-segment driver; next generation of the two-digit display top.
- Scans NUM_DIGITS hex digits onto one shared active-low segment bus and one active-low anode per digit.
- Inserts a programmable dead-time between digit slots to prevent ghosting.
- Takes a per-frame coherent snapshot of the digit inputs. Sits between datapath logic (sum or counter values) and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; legal range 2..8.
- REFRESH_DIV, 25000, clock cycles each digit is driven (DRIVE slot length); must be >= 1.
- BLANK_CYCLES, 50, dead-time cycles between slots with all anodes off; 0 is legal and means no dead-time.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- digits  input  4*NUM_DIGITS  hex values; digits[4*i+3:4*i] is digit i; digit 0 is least significant (rightmost).
- blank_mask  input  NUM_DIGITS  bit i = 1 keeps digit i dark during its slot; slot timing is unchanged.
- seg  output  7  active-low segments {g,f,e,d,c,b,a}; seg[0]=a.
- anode  output  NUM_DIGITS  active-low digit enables; at most one bit is low at any time.
- frame_start  output  1  one-cycle pulse on the first DRIVE cycle of digit 0.

Behaviour:
- Reset is synchronous; reset is sampled at clk rising edge.
  - While reset is high: seg=7'b1111111, anode=all 1s, frame_start=0, digit index=0, counters=0, state=BLANK, shadow register=0.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: BLANK and DRIVE.
  - BLANK: anode all 1s, seg=7'b1111111. Lasts BLANK_CYCLES cycles, then moves to DRIVE for the current index. If BLANK_CYCLES=0, BLANK is skipped entirely: DRIVE of index k+1 directly follows DRIVE of index k.
  - DRIVE: anode[idx]=0 (unless blank_mask[idx]=1, then all 1s); seg=decode(shadow digit idx); lasts exactly REFRESH_DIV cycles, then index advances to BLANK.
- Index advance: idx+1; wraps from NUM_DIGITS-1 to 0.
- Post-reset sequence: BLANK_CYCLES blank cycles, then DRIVE digit 0, with frame_start=1 on that first cycle.
- Frame period = NUM_DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.
- Snapshot rule: the digits input is captured into the shadow register on the clock edge that begins DRIVE of digit 0.
  - Every digit shown in that frame uses the shadow value.
  - Changes to digits mid-frame appear only from the next frame_start.
- blank_mask is sampled live every cycle; it is not snapshotted.
- Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Reset mid-operation: on the next edge, outputs return to reset values and the sequence restarts from the post-reset BLANK.
- Illegal parameters (NUM_DIGITS outside 2..8, REFRESH_DIV<1) are rejected by an elaboration-time $error.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined: digit i (i>=1) is dark during its slot when shadow digit i and all higher shadow digits are 0. Digit 0 is never suppressed. Slot timing is unchanged.
- Undefined: zeros are displayed normally; only blank_mask darkens digits.

Decomposition:
- Package seven_seg_pkg holds:
  - SEG_OFF constant (7'b1111111).
  - 16-entry seg code constant array.
  - typedef enum logic {BLANK, DRIVE} scan_state_t.
- Sub-module hex_to_seg: purely combinational 4-bit to 7-bit active-low decoder, using the package array. Instantiated once on the muxed shadow nibble.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1 unless noted):
- Reset held 3 cycles, digits=16'h1234 -> during reset anode=4'b1111, seg=1111111; after release: 1 blank cycle, then anode=4'b1110, seg=0011001 for 4 cycles, frame_start=1 only on the first of those cycles.
- Continue scan of 16'h1234 -> digit slots in order anode 1101/seg 0110000, 1011/0100100, 0111/1111001, each separated by 1 cycle of anode=1111; frame_start recurs every 20 cycles.
- Change digits to 16'hF980 during the digit 1 slot -> rest of the frame still shows 1234; the next frame shows 0000000(0 at index 0? no: index0=0 -> 1000000), 0000000, 0010000, 0001110 for indices 0..3.
- blank_mask=4'b0100 with digits=16'hABCD -> index 2 slot keeps anode=1111 for 4 cycles; other indices show d/C/A normally; period stays 20 cycles.
- BLANK_CYCLES=0 with reset asserted mid-DRIVE of index 2 -> next edge gives reset values; after release, anode=1110 appears on the first cycle; slots are back-to-back with no all-off cycles.
- With SEVEN_SEG_LEADING_ZERO_BLANK_EN defined, digits=16'h0050 -> indices 3 and 2 dark, index 1 shows 0010010, index 0 shows 1000000; digits=16'h0000 -> only index 0 lit, showing 1000000.

Source files
------------

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared constants and types for the multiplexed seven-segment
//               display driver: the all-off segment pattern, the active-low
//               hex glyph table and the scan FSM state type.
// Ports       : none (package)
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

   // All segments dark (active-low bus)
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Active-low glyphs {g,f,e,d,c,b,a} indexed by hex value 0..F
   localparam logic [6:0] SEG_CODES [16] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/seven_seg_mux_n_hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg
// Description : Purely combinational 4-bit hex to 7-bit active-low segment
//               decoder driven from the shared glyph table.
// Ports       : i_hex  [3:0] hex value to display
//               o_seg  [6:0] active-low segments {g,f,e,d,c,b,a}
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_CODES[i_hex];

endmodule : hex_to_seg
`default_nettype wire

// File: rtl/seven_seg_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_mux_n
// Description : N-digit time-multiplexed seven-segment driver. Scans hex
//               digits onto a shared active-low segment bus with one
//               active-low anode per digit, inserting an all-off dead-time
//               between slots. The digit vector is snapshotted once per frame
//               on the edge that starts digit 0's slot.
// Ports       : clk          system clock
//               reset        synchronous active-high reset
//               digits       4*NUM_DIGITS hex values, digit 0 rightmost/LSB
//               blank_mask   per-digit dark request, sampled live
//               seg          active-low segments {g,f,e,d,c,b,a} (registered)
//               anode        active-low digit enables (registered)
//               frame_start  one-cycle pulse on first drive cycle of digit 0
// Config      : SEVEN_SEG_LEADING_ZERO_BLANK_EN - when defined, digit i (i>=1)
//               stays dark while it and all higher snapshotted digits are 0.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_mux_n
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 25000,
   parameter int BLANK_CYCLES = 50
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic                    frame_start
);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------------
   if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_num_digits
      $error("seven_seg_mux_n: NUM_DIGITS must be in 2..8");
   end
   if (REFRESH_DIV < 1) begin : g_bad_refresh_div
      $error("seven_seg_mux_n: REFRESH_DIV must be >= 1");
   end
   if (BLANK_CYCLES < 0) begin : g_bad_blank_cycles
      $error("seven_seg_mux_n: BLANK_CYCLES must be >= 0");
   end

   // One counter serves both slot kinds, so size it for the longer one
   localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] c_drive_last = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] c_blank_last = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] c_idx_last   = IDX_W'(NUM_DIGITS - 1);

   // With no dead-time the scan must begin directly in digit 0's slot
   localparam scan_state_t c_reset_state = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

   // ------------------------------------------------------------------------
   // Scan state. r_state/r_idx/r_cnt describe the cycle whose outputs are
   // loaded on the next edge, so the outputs are a registered image of the
   // scan position and the first post-reset cycle is a real blank cycle.
   // ------------------------------------------------------------------------
   scan_state_t              r_state;
   logic [IDX_W-1:0]         r_idx;
   logic [CNT_W-1:0]         r_cnt;
   logic [4*NUM_DIGITS-1:0]  r_shadow;

   logic                     w_frame_begin;
   logic [4*NUM_DIGITS-1:0]  w_view;
   logic [3:0]               w_nibble;
   logic [6:0]               w_seg;
   logic                     w_dark;
   logic [NUM_DIGITS-1:0]    w_anode_on;

   assign w_frame_begin = (r_state == DRIVE) && (r_idx == '0) && (r_cnt == '0);

   // The snapshot is taken on the same edge that loads digit 0's outputs, so
   // that slot decodes straight from the value being captured.
   assign w_view   = w_frame_begin ? digits : r_shadow;
   assign w_nibble = w_view[{r_idx, 2'b00} +: 4];

   hex_to_seg u_hex_to_seg (
      .i_hex (w_nibble),
      .o_seg (w_seg)
   );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
   // Digit idx is a leading zero when it and everything above it is zero
   assign w_dark = blank_mask[r_idx]
                 | ((r_idx != '0) && ((w_view >> {r_idx, 2'b00}) == '0));
`else
   assign w_dark = blank_mask[r_idx];
`endif

   assign w_anode_on = ~(NUM_DIGITS'(1) << r_idx);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= c_reset_state;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_shadow    <= '0;
         seg         <= SEG_OFF;
         anode       <= '1;
         frame_start <= 1'b0;
      end else begin
         case (r_state)
            BLANK: begin
               seg         <= SEG_OFF;
               anode       <= '1;
               frame_start <= 1'b0;
               if (r_cnt == c_blank_last) begin
                  r_state <= DRIVE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DRIVE: begin
               seg         <= w_seg;
               anode       <= w_dark ? '1 : w_anode_on;
               frame_start <= w_frame_begin;
               if (w_frame_begin) begin
                  r_shadow <= digits;
               end
               if (r_cnt == c_drive_last) begin
                  r_cnt   <= '0;
                  r_idx   <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
                  r_state <= (BLANK_CYCLES == 0) ? DRIVE : BLANK;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= c_reset_state;
            end
         endcase
      end
   end

endmodule : seven_seg_mux_n
`default_nettype wire

// File: tb/tb_seven_seg_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_mux_n
// Description : Self-checking bench for seven_seg_mux_n. Two instances
//               (BLANK_CYCLES=1 and BLANK_CYCLES=0, NUM_DIGITS=4,
//               REFRESH_DIV=4) share random stimulus; each cycle their
//               outputs are compared with a frame-arithmetic reference model.
// Config      : honours SEVEN_SEG_LEADING_ZERO_BLANK_EN in the model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_mux_n;

   localparam int N = 4;
   localparam int R = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [15:0]   digits;
   logic [3:0]    blank_mask;

   logic [6:0]    seg_a, seg_b;
   logic [3:0]    anode_a, anode_b;
   logic          fs_a, fs_b;

   int            n_checks = 0;
   int            n_errors = 0;

   always #5 clk = ~clk;

   seven_seg_mux_n #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(1)) u_dut_b1 (
      .clk         (clk),
      .reset       (reset),
      .digits      (digits),
      .blank_mask  (blank_mask),
      .seg         (seg_a),
      .anode       (anode_a),
      .frame_start (fs_a)
   );

   seven_seg_mux_n #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(0)) u_dut_b0 (
      .clk         (clk),
      .reset       (reset),
      .digits      (digits),
      .blank_mask  (blank_mask),
      .seg         (seg_b),
      .anode       (anode_b),
      .frame_start (fs_b)
   );

   // Glyphs written out from the display table
   logic [6:0] glyph [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: position in the frame is derived from the number of
   // cycles since reset release; the frame period is N*(R+B).
   // ------------------------------------------------------------------------
   int          t_since   [2] = '{0, 0};
   logic [15:0] shadow_m  [2] = '{16'h0, 16'h0};

   always @(posedge clk) begin
      logic        s_reset;
      logic [15:0] s_digits;
      logic [3:0]  s_mask;
      s_reset  = reset;
      s_digits = digits;
      s_mask   = blank_mask;
      #1;
      for (int k = 0; k < 2; k++) begin
         int         b, slot_len, period, pos, s, off;
         logic [6:0] e_seg, o_seg;
         logic [3:0] e_an, o_an;
         logic       e_fs, o_fs, dark;
         string      sfx;
         b        = (k == 0) ? 1 : 0;
         slot_len = R + b;
         period   = N * slot_len;
         sfx      = (k == 0) ? "b1" : "b0";
         o_seg    = (k == 0) ? seg_a   : seg_b;
         o_an     = (k == 0) ? anode_a : anode_b;
         o_fs     = (k == 0) ? fs_a    : fs_b;
         e_seg    = 7'b1111111;
         e_an     = 4'b1111;
         e_fs     = 1'b0;
         if (s_reset) begin
            t_since[k] = 0;
         end else begin
            pos = t_since[k] % period;
            s   = pos / slot_len;
            off = pos % slot_len;
            if (off >= b) begin
               if (s == 0 && off == b) begin
                  shadow_m[k] = s_digits;
                  e_fs        = 1'b1;
               end
               e_seg = glyph[(shadow_m[k] >> (4 * s)) & 16'hF];
               dark  = s_mask[s];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
               if (s >= 1 && (shadow_m[k] >> (4 * s)) == 16'h0) dark = 1'b1;
`endif
               e_an = dark ? 4'b1111 : ~(4'b0001 << s);
            end
            t_since[k]++;
         end
         check({"seg_", sfx},   32'(o_seg), 32'(e_seg));
         check({"anode_", sfx}, 32'(o_an),  32'(e_an));
         check({"fs_", sfx},    32'(o_fs),  32'(e_fs));
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus: directed opening (1234, mid-frame change to F980, mask on
   // ABCD) followed by random digits/mask/reset activity.
   // ------------------------------------------------------------------------
   initial begin
      reset      = 1'b1;
      digits     = 16'h1234;
      blank_mask = 4'b0000;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (27) @(negedge clk);   // into digit 1 slot of the second frame
      digits = 16'hF980;
      repeat (40) @(negedge clk);
      digits     = 16'hABCD;
      blank_mask = 4'b0100;
      repeat (40) @(negedge clk);
      blank_mask = 4'b0000;
      digits     = 16'h0050;
      repeat (40) @(negedge clk);
      digits = 16'h0000;
      repeat (40) @(negedge clk);
      // Reset landing mid-DRIVE of index 2 for the no-dead-time instance
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 24) == 0) begin
            logic [31:0] r;
            int          w;
            r      = $urandom;
            w      = $urandom_range(0, 4);
            digits = (w == 4) ? r[15:0] : (r[15:0] & 16'((32'h1 << (4 * w)) - 1));
         end
         if ($urandom_range(0, 49) == 0)
            blank_mask = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
         if (reset)
            reset = ($urandom_range(0, 2) == 0);
         else if ($urandom_range(0, 299) == 0)
            reset = 1'b1;
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_seven_seg_mux_n
`default_nettype wire
